// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the data-bus arbiter slice.
package wb_pkg;

  localparam int NUM_ARB_PORTS = 3;

  typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_t;

  typedef logic [3:0] wrr_credit_t;

  // Next port in the fixed rotation 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Index of the set bit of a one-hot 3-bit vector (0 when empty).
  function automatic logic [1:0] onehot_to_idx(input logic [2:0] g);
    return g[1] ? 2'd1 : (g[2] ? 2'd2 : 2'd0);
  endfunction

endpackage

// File: rtl/wb_if.sv
// Pipelined Wishbone bundle; stall is the pipelined-mode back-pressure.
interface wb_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   adr;
  logic [SELECT_WIDTH-1:0] sel;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic                    ack;
  logic                    err;
  logic                    stall;

  modport master (output cyc, stb, we, adr, sel, dat_w,
                  input  dat_r, ack, err, stall);
  modport slave  (input  cyc, stb, we, adr, sel, dat_w,
                  output dat_r, ack, err, stall);
endinterface

// File: rtl/wb_rr_pick.sv
// First requester in rotating order beginning at start.
module wb_rr_pick
  import wb_pkg::*;
(
  input  logic [NUM_ARB_PORTS-1:0] req,
  input  logic [1:0]               start,
  output logic [NUM_ARB_PORTS-1:0] pick,
  output logic                     any
);

  logic       found;
  logic [1:0] idx;

  // Walk the three ports from start and take the first one requesting.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = start;
    for (int i = 0; i < NUM_ARB_PORTS; i++) begin
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
      idx = next_port(idx);
    end
  end

  assign any = |req;

endmodule

// File: rtl/wb_wrr_arbiter_3.sv
// Three-master pipelined Wishbone arbiter with weighted round-robin tenures.
// A tenure is one full cyc assertion; it is never preempted.
module wb_wrr_arbiter_3
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int WEIGHT_0     = 4,
  parameter int WEIGHT_1     = 2,
  parameter int WEIGHT_2     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  wb_if.slave                      wbm [NUM_ARB_PORTS],
  wb_if.master                     wbs,
  output logic [NUM_ARB_PORTS-1:0] grant,
  output logic                     grant_valid
);

  localparam wrr_credit_t RELOAD_0 = wrr_credit_t'(WEIGHT_0 - 1);
  localparam wrr_credit_t RELOAD_1 = wrr_credit_t'(WEIGHT_1 - 1);
  localparam wrr_credit_t RELOAD_2 = wrr_credit_t'(WEIGHT_2 - 1);

  arb_state_t  state;
  wrr_credit_t credit;
  wrr_credit_t reload;
  logic [1:0]  last;
  logic [1:0]  start;
  logic [1:0]  pick_idx;
  logic [NUM_ARB_PORTS-1:0] pick;
  logic        any;
  logic        owner_cyc;
  logic        free;

  logic [NUM_ARB_PORTS-1:0] m_cyc;
  logic [NUM_ARB_PORTS-1:0] m_stb;
  logic [NUM_ARB_PORTS-1:0] m_we;
  logic [ADDR_WIDTH-1:0]    m_adr   [NUM_ARB_PORTS];
  logic [SELECT_WIDTH-1:0]  m_sel   [NUM_ARB_PORTS];
  logic [DATA_WIDTH-1:0]    m_dat_w [NUM_ARB_PORTS];

  logic                     fwd_cyc;
  logic                     fwd_stb;
  logic                     fwd_we;
  logic [ADDR_WIDTH-1:0]    fwd_adr;
  logic [SELECT_WIDTH-1:0]  fwd_sel;
  logic [DATA_WIDTH-1:0]    fwd_dat_w;

  // Flatten the interface array so the mux can index it with a variable.
  // Return paths are gated by the registered grant; grant is all-zero in
  // IDLE and during reset, so every port then sees stall=1 and no response.
  for (genvar i = 0; i < NUM_ARB_PORTS; i++) begin : g_port
    assign m_cyc[i]       = wbm[i].cyc;
    assign m_stb[i]       = wbm[i].stb;
    assign m_we[i]        = wbm[i].we;
    assign m_adr[i]       = wbm[i].adr;
    assign m_sel[i]       = wbm[i].sel;
    assign m_dat_w[i]     = wbm[i].dat_w;
    assign wbm[i].dat_r   = grant[i] ? wbs.dat_r : '0;
    assign wbm[i].ack     = grant[i] & wbs.ack;
    assign wbm[i].err     = grant[i] & wbs.err;
    assign wbm[i].stall   = grant[i] ? wbs.stall : 1'b1;
  end

  // The bus is free when nobody owns it or the owner has dropped cyc; a
  // release and new requests in the same cycle resolve in one decision.
  assign owner_cyc = |(grant & m_cyc);
  assign free      = (state == ARB_IDLE) || !owner_cyc;

  // Remaining credit keeps the last owner at the head of the rotation.
  assign start = (credit != '0) ? last : next_port(last);

  wb_rr_pick u_pick (
    .req   (m_cyc),
    .start (start),
    .pick  (pick),
    .any   (any)
  );

  assign pick_idx = onehot_to_idx(pick);

  // Credit loaded when a different port takes the bus.
  always_comb begin
    case (pick_idx)
      2'd0:    reload = RELOAD_0;
      2'd1:    reload = RELOAD_1;
      default: reload = RELOAD_2;
    endcase
  end

  // Ownership FSM with registered grant, last owner and credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      last        <= 2'd2;
      credit      <= '0;
    end else if (free) begin
      if (any) begin
        state       <= ARB_OWNED;
        grant       <= pick;
        grant_valid <= 1'b1;
        last        <= pick_idx;
        // A regrant to the last owner with no credit left (it was the only
        // requester) holds credit at zero rather than wrapping.
        if (pick_idx == last)
          credit <= (credit != '0) ? credit - 4'd1 : '0;
        else
          credit <= reload;
      end else begin
        state       <= ARB_IDLE;
        grant       <= '0;
        grant_valid <= 1'b0;
      end
    end
  end

  // Downstream request path straight from the current owner, no register.
  always_comb begin
    fwd_cyc   = 1'b0;
    fwd_stb   = 1'b0;
    fwd_we    = 1'b0;
    fwd_adr   = '0;
    fwd_sel   = '0;
    fwd_dat_w = '0;
    for (int i = 0; i < NUM_ARB_PORTS; i++) begin
      if (grant[i]) begin
        fwd_cyc   = m_cyc[i];
        fwd_stb   = m_stb[i];
        fwd_we    = m_we[i];
        fwd_adr   = m_adr[i];
        fwd_sel   = m_sel[i];
        fwd_dat_w = m_dat_w[i];
      end
    end
  end

  assign wbs.cyc   = fwd_cyc;
  assign wbs.stb   = fwd_stb;
  assign wbs.we    = fwd_we;
  assign wbs.adr   = fwd_adr;
  assign wbs.sel   = fwd_sel;
  assign wbs.dat_w = fwd_dat_w;

endmodule

// File: tb/tb_wb_wrr_arbiter_3.sv
// Scoreboarded bench for wb_wrr_arbiter_3: stimulus pushes expected grants,
// a negedge monitor pops them whenever a new grant appears.
module tb_wb_wrr_arbiter_3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_if wbm [3] ();
  wb_if wbs ();

  logic [2:0] grant;
  logic       grant_valid;

  wb_wrr_arbiter_3 dut (
    .clk         (clk),
    .rst         (rst),
    .wbm         (wbm),
    .wbs         (wbs),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  logic [2:0]  m_cyc, m_stb, m_we;
  logic [31:0] m_adr   [3];
  logic [3:0]  m_sel   [3];
  logic [31:0] m_dat_w [3];
  logic [2:0]  o_stall, o_ack, o_err;
  logic [31:0] o_dat_r [3];

  for (genvar i = 0; i < 3; i++) begin : g_m
    assign wbm[i].cyc   = m_cyc[i];
    assign wbm[i].stb   = m_stb[i];
    assign wbm[i].we    = m_we[i];
    assign wbm[i].adr   = m_adr[i];
    assign wbm[i].sel   = m_sel[i];
    assign wbm[i].dat_w = m_dat_w[i];
    assign o_stall[i]   = wbm[i].stall;
    assign o_ack[i]     = wbm[i].ack;
    assign o_err[i]     = wbm[i].err;
    assign o_dat_r[i]   = wbm[i].dat_r;
  end

  // Slave model: never stalls, answers one cycle after each accepted beat.
  localparam logic [31:0] ERR_ADR = 32'hDEAD_0000;
  localparam logic [31:0] RD_MASK = 32'h5A5A_0000;
  logic        s_ack, s_err;
  logic [31:0] s_dat;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack <= 1'b0; s_err <= 1'b0; s_dat <= '0;
    end else begin
      s_ack <= wbs.cyc && wbs.stb && (wbs.adr != ERR_ADR);
      s_err <= wbs.cyc && wbs.stb && (wbs.adr == ERR_ADR);
      s_dat <= wbs.adr ^ RD_MASK;
    end
  end
  assign wbs.ack   = s_ack;
  assign wbs.err   = s_err;
  assign wbs.dat_r = s_dat;
  assign wbs.stall = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for the arbiter", name);
  endtask

  // Scoreboard of expected grants, consumed by the monitor.
  logic [2:0] exp_q [$];
  logic       prev_gv;
  logic [2:0] prev_grant;
  always @(negedge clk) begin
    if (rst) begin
      prev_gv    <= 1'b0;
      prev_grant <= '0;
    end else begin
      if (grant_valid && (!prev_gv || grant != prev_grant)) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL grant_seq: got %b, required no new grant", grant);
        end else begin
          check("grant_seq", {29'd0, grant}, {29'd0, exp_q.pop_front()});
        end
      end
      prev_gv    <= grant_valid;
      prev_grant <= grant;
    end
  end

  // Length of the most recent run of wbs.cyc=0 cycles between tenures.
  int gap_run = 0;
  int last_gap = 0;
  always @(negedge clk) begin
    if (rst) begin
      gap_run <= 0;
    end else if (!wbs.cyc) begin
      gap_run <= gap_run + 1;
    end else begin
      if (gap_run != 0) last_gap <= gap_run;
      gap_run <= 0;
    end
  end

  task automatic wait_resp(input int p, input logic we, input logic [31:0] adr);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (!(o_ack[p] || o_err[p]) && t < 100);
    if (!(o_ack[p] || o_err[p])) timeout("response");
    else if (!we && o_ack[p]) check("read_data", o_dat_r[p], adr ^ RD_MASK);
  endtask

  // One single-beat tenure on port p; waits for grant while holding stb.
  task automatic single(input int p, input logic [31:0] adr, input logic we);
    int t;
    @(posedge clk); #1;
    m_cyc[p] = 1'b1; m_stb[p] = 1'b1; m_we[p] = we;
    m_adr[p] = adr;  m_sel[p] = 4'hF; m_dat_w[p] = adr + 32'd1;
    t = 0;
    do begin @(negedge clk); t++; end while (o_stall[p] && t < 200);
    if (o_stall[p]) timeout("grant_wait");
    @(posedge clk); #1;
    m_stb[p] = 1'b0;
    wait_resp(p, we, adr);
    @(posedge clk); #1;
    m_cyc[p] = 1'b0; m_we[p] = 1'b0;
  endtask

  // All three ports raise cyc together from idle; losers withdraw once the
  // winner is known, the winner completes one read.
  task automatic round_all(input logic [31:0] base);
    int t;
    int w;
    @(posedge clk); #1;
    for (int p = 0; p < 3; p++) begin
      m_cyc[p] = 1'b1; m_stb[p] = 1'b1; m_we[p] = 1'b0;
      m_adr[p] = base + 32'(p * 16);
    end
    t = 0;
    do begin @(negedge clk); t++; end while (o_stall == 3'b111 && t < 50);
    w = !o_stall[0] ? 0 : (!o_stall[1] ? 1 : 2);
    if (o_stall == 3'b111) timeout("round_grant");
    @(posedge clk); #1;
    for (int p = 0; p < 3; p++) begin
      m_stb[p] = 1'b0;
      if (p != w) m_cyc[p] = 1'b0;
    end
    wait_resp(w, 1'b0, base + 32'(w * 16));
    @(posedge clk); #1;
    m_cyc[w] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [2:0] rot_exp [12];

  initial begin
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0;
    for (int p = 0; p < 3; p++) begin
      m_adr[p] = '0; m_sel[p] = '0; m_dat_w[p] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_grant", {29'd0, grant}, 32'd0);
    check("rst_grant_valid", {31'd0, grant_valid}, 32'd0);
    check("rst_wbs_cyc", {31'd0, wbs.cyc}, 32'd0);
    check("rst_stall", {29'd0, o_stall}, 32'd7);
    check("rst_ack", {29'd0, o_ack}, 32'd0);

    // Weighted rotation: weights 4/2/1 starting at port 0.
    rot_exp = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010,
                3'b100, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
    for (int r = 0; r < 12; r++) begin
      exp_q.push_back(rot_exp[r]);
      round_all(32'h1000_0000 + 32'(r * 256));
    end
    // Now last=1 with credit 1.

    // Non-preemption and handover latency.
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    fork
      begin : p0_long
        int beats, acks, viol;
        logic acc;
        beats = 0; acks = 0; viol = 0;
        @(posedge clk); #1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0;
        m_adr[0] = 32'h2000_0000; m_sel[0] = 4'hF;
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          acc = m_stb[0] && !o_stall[0];
          if (o_ack[0]) acks++;
          if (!o_stall[1] || !o_stall[2] || o_ack[1] || o_ack[2] ||
              o_dat_r[1] != 0 || o_dat_r[2] != 0) viol++;
          @(posedge clk); #1;
          if (acc) begin
            beats++;
            m_adr[0] = m_adr[0] + 32'd4;
            if (beats == 8) m_stb[0] = 1'b0;
          end
        end
        m_cyc[0] = 1'b0;
        @(negedge clk);
        check("release_wbs_cyc", {31'd0, wbs.cyc}, 32'd0);
        check("release_grant", {29'd0, grant}, 32'b001);
        @(negedge clk);
        check("handover_grant", {29'd0, grant}, 32'b010);
        check("handover_stb", {31'd0, wbs.stb}, 32'd1);
        check("handover_adr", wbs.adr, 32'h3000_0010);
        check("p0_acks", acks, 32'd8);
        check("nonowner_blocked", viol, 32'd0);
      end
      begin
        repeat (2) @(posedge clk);
        fork
          single(1, 32'h3000_0010, 1'b0);
          single(2, 32'h3000_0020, 1'b0);
        join
      end
    join
    check("handover_gap", last_gap, 32'd1);
    // Now last=2 with credit 0.

    // Idle skip: only port 2; each regrant passes through one idle cycle.
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(3'b100);
      single(2, 32'h4000_0000 + 32'(k * 4), 1'b0);
      if (k > 0) check("same_port_gap", last_gap, 32'd2);
    end

    // Error passthrough on port 1's write; ports 0 and 2 wait behind it.
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    fork
      single(1, ERR_ADR, 1'b1);
      begin
        repeat (2) @(posedge clk);
        fork
          single(0, 32'h5000_0000, 1'b0);
          single(2, 32'h5000_0010, 1'b0);
        join
      end
      begin
        int t;
        t = 0;
        do begin @(negedge clk); t++; end while (!s_err && t < 50);
        if (!s_err) timeout("err_wait");
        check("err_route", {29'd0, o_err}, 32'b010);
        check("err_grant", {29'd0, grant}, 32'b010);
        @(negedge clk);
        check("err_one_cycle", {29'd0, o_err}, 32'd0);
      end
    join
    // Now last=0 with credit 3.

    // Asynchronous reset in the middle of port 1's tenure.
    exp_q.push_back(3'b010);
    @(posedge clk); #1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[1] = 32'h6000_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_rst_grant", {29'd0, grant}, 32'b010);
    #2 rst = 1'b1;
    #1;
    check("rst_async_wbs_cyc", {31'd0, wbs.cyc}, 32'd0);
    check("rst_async_grant", {29'd0, grant}, 32'd0);
    check("rst_async_valid", {31'd0, grant_valid}, 32'd0);
    m_cyc = '0; m_stb = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(3'b001);
    round_all(32'h7000_0000);

    repeat (5) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
